ps2_rx_controller: RTL

PS2_RX_CONTROLLER -- requirements
Module: ps2_rx_controller

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_rx_fifo.sv | 78 +++++++
 rtl/ps2_rx_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive controller.
//   - ps2_state_e      : receive FSM state encoding
//   - FRAME_DATA_BITS  : data bits per PS/2 frame
//   - ERR_*            : bit positions inside err_flags {overrun, frame, parity}
//   - *_DEFAULT        : parameter defaults for ps2_rx_controller
//   - odd_parity_ok()  : true when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

    localparam int unsigned FRAME_DATA_BITS        = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT     = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;

    localparam int unsigned ERR_PARITY  = 0;
    localparam int unsigned ERR_FRAME   = 1;
    localparam int unsigned ERR_OVERRUN = 2;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                           input logic                       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: first-word-fall-through scancode FIFO.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   push, push_data   : write strobe and byte; ignored when full unless popping in the same cycle
//   pop               : read strobe; ignored when empty
//   full, empty       : occupancy status (registered)
//   head_data         : oldest entry, 0 while empty
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = FRAME_DATA_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_controller.sv
// ps2_rx_controller: PS/2 device-to-host receiver with scancode FIFO.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   ps2_clk_i    : raw PS/2 clock line      ps2_data_i : raw PS/2 data line
//   ps2_clk_oe   : 1 = pull PS/2 clock low (inhibit) while FIFO full and receiver idle
//   rd_req       : pop strobe               rd_data    : FIFO head (0 when empty)
//   rd_valid     : FIFO not empty           irq        : level interrupt, same as rd_valid
//   err_flags    : sticky {overrun, frame, parity}; err_clr clears (a same-cycle set wins)
// Build option: define PS2_TIMEOUT_EN to add a mid-frame PS/2 clock timeout that returns the
// receiver to idle and raises the frame flag after TIMEOUT_CYCLES clk cycles without an edge.
module ps2_rx_controller
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       irq,
    output logic [2:0] err_flags,
    input  logic       err_clr
);

    localparam int unsigned BitCntW = $clog2(FRAME_DATA_BITS);

    // Synchronisers; all reset high so releasing reset never looks like a falling edge.
    logic [1:0] ps2_clk_sync_q, ps2_clk_sync_d;
    logic [1:0] ps2_data_sync_q, ps2_data_sync_d;
    logic       ps2_clk_prev_q, ps2_clk_prev_d;
    logic       fall_edge;
    logic       bit_in;

    assign ps2_clk_sync_d  = {ps2_clk_sync_q[0], ps2_clk_i};
    assign ps2_data_sync_d = {ps2_data_sync_q[0], ps2_data_i};
    assign ps2_clk_prev_d  = ps2_clk_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_sync_q  <= 2'b11;
            ps2_data_sync_q <= 2'b11;
            ps2_clk_prev_q  <= 1'b1;
        end else begin
            ps2_clk_sync_q  <= ps2_clk_sync_d;
            ps2_data_sync_q <= ps2_data_sync_d;
            ps2_clk_prev_q  <= ps2_clk_prev_d;
        end
    end

    assign fall_edge = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
    assign bit_in    = ps2_data_sync_q[1];

    // Receive FSM
    ps2_state_e                 state_q, state_d;
    logic [BitCntW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       frame_bad_q, frame_bad_d;
    logic                       push_q, push_d;
    logic [FRAME_DATA_BITS-1:0] push_data_q, push_data_d;
    logic                       set_parity, set_frame;
    logic                       tmo_fire;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_fire  = 1'b0;
        if (fall_edge || (state_q == StIdle)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES)) begin
            tmo_fire  = 1'b1;
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_bad_d = frame_bad_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        set_parity  = 1'b0;
        set_frame   = 1'b0;
        if (fall_edge) begin
            unique case (state_q)
                StIdle: begin
                    // A high start bit is line noise, not a frame: ignore silently.
                    if (!bit_in) begin
                        state_d     = StData;
                        bit_cnt_d   = '0;
                        frame_bad_d = 1'b0;
                    end
                end
                StData: begin
                    shift_d = {bit_in, shift_q[FRAME_DATA_BITS-1:1]};
                    if (bit_cnt_q == BitCntW'(FRAME_DATA_BITS - 1)) begin
                        state_d = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (!odd_parity_ok(shift_q, bit_in)) begin
                        set_parity  = 1'b1;
                        frame_bad_d = 1'b1;
                    end
                    state_d = StStop;
                end
                StStop: begin
                    if (bit_in) begin
                        push_d      = ~frame_bad_q;
                        push_data_d = shift_q;
                    end else begin
                        set_frame = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (tmo_fire) begin
            state_d   = StIdle;
            set_frame = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_bad_q <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_bad_q <= frame_bad_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // Scancode FIFO
    logic fifo_full, fifo_empty, fifo_pop;

    assign fifo_pop = rd_req & ~fifo_empty;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (rd_data)
    );

    // Sticky error flags
    logic [2:0] err_q, err_d;

    always_comb begin
        err_d = err_clr ? 3'b000 : err_q;
        if (set_parity) begin
            err_d[ERR_PARITY] = 1'b1;
        end
        if (set_frame) begin
            err_d[ERR_FRAME] = 1'b1;
        end
        if (push_q && fifo_full && !fifo_pop) begin
            err_d[ERR_OVERRUN] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flags  = err_q;
    assign rd_valid   = ~fifo_empty;
    assign irq        = ~fifo_empty;
    // Only inhibit between frames so a frame in flight is never cut short.
    assign ps2_clk_oe = fifo_full & (state_q == StIdle);

endmodule
